// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: restarts the PLL, qualifies its synchronised lock flag,
// and releases the PLL clock domain only after lock has been stable long enough.
module pll_lock_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 60000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart_req,
  input  logic       clear_status,
  output logic       pll_resetb,
  output logic       domain_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             pll_resetb_q, pll_resetb_d;
  logic             domain_rst_n_q, domain_rst_n_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic [7:0]       retry_q, retry_d;
  logic             lk;
  logic             retry_inc;
  logic             lost_set;

  assign lk = sync2_q;

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    lost_set  = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RESET_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (restart_req) begin
          state_d = RESET_PLL;
        end else if (lk) begin
          state_d = STABILIZE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = RESET_PLL;
          retry_inc = 1'b1;
        end
      end
      STABILIZE: begin
        if (restart_req) begin
          state_d = RESET_PLL;
        end else if (!lk) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Lock loss is checked first so a coincident restart still counts as a retry.
        if (!lk) begin
          state_d   = RESET_PLL;
          lost_set  = 1'b1;
          retry_inc = 1'b1;
        end else if (restart_req) begin
          state_d = RESET_PLL;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    retry_d = (retry_inc && (retry_q != 8'hFF)) ? retry_q + 8'd1 : retry_q;

    if (lost_set) begin
      lock_lost_d = 1'b1;
    end else if (clear_status) begin
      lock_lost_d = 1'b0;
    end else begin
      lock_lost_d = lock_lost_q;
    end

    // Decode from the next state so outputs change on the same edge as the state.
    pll_resetb_d   = (state_d != RESET_PLL);
    domain_rst_n_d = (state_d == RUN);
    ready_d        = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RESET_PLL;
      cnt_q          <= '0;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      pll_resetb_q   <= 1'b0;
      domain_rst_n_q <= 1'b0;
      ready_q        <= 1'b0;
      lock_lost_q    <= 1'b0;
      retry_q        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sync1_q        <= pll_locked;
      sync2_q        <= sync1_q;
      pll_resetb_q   <= pll_resetb_d;
      domain_rst_n_q <= domain_rst_n_d;
      ready_q        <= ready_d;
      lock_lost_q    <= lock_lost_d;
      retry_q        <= retry_d;
    end
  end

  assign pll_resetb   = pll_resetb_q;
  assign domain_rst_n = domain_rst_n_q;
  assign ready        = ready_q;
  assign lock_lost    = lock_lost_q;
  assign retry_count  = retry_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock/restart traffic,
// every cycle compared against a timestamp-based behavioural model.
module tb_pll_lock_sequencer;

  localparam int RC = 4;
  localparam int LT = 100;
  localparam int SC = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart_req = 1'b0;
  logic       clear_status = 1'b0;
  logic       pll_resetb, domain_rst_n, ready, lock_lost;
  logic [7:0] retry_count;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .CNT_W        (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .restart_req (restart_req),
    .clear_status(clear_status),
    .pll_resetb  (pll_resetb),
    .domain_rst_n(domain_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_count (retry_count),
    .state       (state)
  );

  always #5 clock = ~clock;

  // Reference model: lk is the raw input two edges back; time in state is edge count since entry.
  bit hist[$];
  int m_state, m_entry, m_retry, cyc;
  bit m_lost;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    hist = '{1'b0, 1'b0};
    m_state = 0; m_entry = 0; m_retry = 0; m_lost = 1'b0; cyc = 0;
  endtask

  task automatic model_edge();
    bit lk;
    int t, nxt;
    bit set_lost;
    cyc++;
    lk = hist[1];
    hist.push_front(pll_locked);
    void'(hist.pop_back());
    t = cyc - 1 - m_entry;
    nxt = m_state;
    set_lost = 1'b0;
    if (m_state == 0) begin
      if (t == RC - 1) nxt = 1;
    end else if (m_state == 1) begin
      if (restart_req) nxt = 0;
      else if (lk) nxt = 2;
      else if (t == LT - 1) begin nxt = 0; if (m_retry < 255) m_retry++; end
    end else if (m_state == 2) begin
      if (restart_req) nxt = 0;
      else if (!lk) nxt = 1;
      else if (t == SC - 1) nxt = 3;
    end else begin
      if (!lk) begin nxt = 0; set_lost = 1'b1; if (m_retry < 255) m_retry++; end
      else if (restart_req) nxt = 0;
    end
    if (set_lost) m_lost = 1'b1;
    else if (clear_status) m_lost = 1'b0;
    if (nxt != m_state) begin m_state = nxt; m_entry = cyc; end
  endtask

  task automatic check_outputs();
    check("state", int'(state), m_state);
    check("pll_resetb", int'(pll_resetb), int'(m_state != 0));
    check("domain_rst_n", int'(domain_rst_n), int'(m_state == 3));
    check("ready", int'(ready), int'(m_state == 3));
    check("lock_lost", int'(lock_lost), int'(m_lost));
    check("retry_count", int'(retry_count), m_retry);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_pll_resetb"}, int'(pll_resetb), 0);
    check({tag, "_domain_rst_n"}, int'(domain_rst_n), 0);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_lock_lost"}, int'(lock_lost), 0);
    check({tag, "_retry"}, int'(retry_count), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pll_locked = 1'b0; restart_req = 1'b0; clear_status = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("rst");
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int k = 0;
    while (int'(state) != s && k < budget) begin step(); k++; end
    check(tag, int'(state), s);
  endtask

  int r0, n, lowcnt;

  initial begin
    #3;
    do_reset();

    // Power-up: lock raised so it is first sampled on edge 10
    for (int e = 1; e <= 22; e++) begin
      if (e == 10) pll_locked = 1'b1;
      step();
      if (e == 3)  check("pwr_resetb_e3", int'(pll_resetb), 0);
      if (e == 4)  check("pwr_resetb_e4", int'(pll_resetb), 1);
      if (e == 19) check("pwr_ready_e19", int'(ready), 0);
      if (e == 22) begin
        check("pwr_ready_e22", int'(ready), 1);
        check("pwr_domain_e22", int'(domain_rst_n), 1);
        check("pwr_retry", int'(retry_count), 0);
      end
    end

    // restart_req in RUN, then a second one during RESET_PLL
    r0 = int'(retry_count);
    restart_req = 1'b1; step(); restart_req = 1'b0;
    check("rr_next_edge", int'(state), 0);
    check("rr_retry", int'(retry_count), r0);
    step();
    restart_req = 1'b1; step(); restart_req = 1'b0;
    step();
    check("rr_pulse_e3", int'(pll_resetb), 0);
    step();
    check("rr_pulse_e4", int'(pll_resetb), 1);
    wait_state(3, 50, "rr_back_to_run");

    // Lock loss in RUN
    r0 = int'(retry_count);
    pll_locked = 1'b0;
    n = 0;
    while (ready && n < 6) begin step(); n++; end
    check("ll_latency", n, 3);
    check("ll_lock_lost", int'(lock_lost), 1);
    check("ll_retry", int'(retry_count), r0 + 1);
    lowcnt = 0;
    while (!pll_resetb && lowcnt < 20) begin lowcnt++; step(); end
    check("ll_resetb_low", lowcnt, RC);
    repeat (5) step();
    clear_status = 1'b1; step(); clear_status = 1'b0;
    check("ll_clear", int'(lock_lost), 0);

    // clear_status coinciding with the set of lock_lost
    pll_locked = 1'b1;
    wait_state(3, 60, "sw_to_run");
    pll_locked = 1'b0;
    step(); step();
    clear_status = 1'b1; step(); clear_status = 1'b0;
    check("sw_set_wins", int'(lock_lost), 1);
    check("sw_ready", int'(ready), 0);

    // Two-cycle lock glitch five cycles into STABILIZE
    wait_state(1, 20, "gl_wait_lock");
    pll_locked = 1'b1;
    wait_state(2, 10, "gl_stabilize");
    repeat (5) step();
    pll_locked = 1'b0; step(); step(); pll_locked = 1'b1;
    wait_state(1, 10, "gl_back_to_wait");
    wait_state(2, 10, "gl_restab");
    n = 0;
    while (!ready && n < 30) begin step(); n++; end
    check("gl_full_qualify", n, SC);

    // Asynchronous reset mid-STABILIZE
    restart_req = 1'b1; step(); restart_req = 1'b0;
    wait_state(2, 30, "ar_stabilize");
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1 check_reset_vals("ar_async");
    do_reset();

    // Timeout retries, then saturation
    repeat (3 * (RC + LT)) step();
    check("to_retry3", int'(retry_count), 3);
    repeat (300 * (RC + LT)) step();
    check("sat_retry", int'(retry_count), 255);

    // Random lock / restart / clear traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
      restart_req  = ($urandom_range(0, 149) == 0);
      clear_status = ($urandom_range(0, 49) == 0);
      step();
    end
    restart_req = 1'b0; clear_status = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
